// File: rtl/m31_stream_accumulator.sv
// m31_stream_accumulator: packet-wise accumulator over the Mersenne-31 field
// (p = 2^31 - 1). It consumes a valid/ready element stream delimited by
// in_last and emits one registered, canonical sum per packet together with a
// saturating element count.
// Optional build macro: M31_ACC_LEN_LIMIT_EN. When it is defined, packets are
// force-closed at MAX_LEN elements and the out_overrun flag is added.
module m31_stream_accumulator #(
  parameter int DATA_WIDTH = 31,
  parameter int MAX_LEN    = 16,
  parameter int CNT_WIDTH  = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  out_count
`ifdef M31_ACC_LEN_LIMIT_EN
  ,
  output logic                  out_overrun
`endif
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_LEN);
  localparam logic [CNT_WIDTH-1:0] ONE_CNT = CNT_WIDTH'(1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   acc;
  logic [CNT_WIDTH-1:0]    cnt;

  logic                    in_xfer;
  logic                    out_xfer;
  logic                    close_pkt;
  logic [DATA_WIDTH-1:0]   base;
  logic [CNT_WIDTH-1:0]    cnt_base;
  logic [DATA_WIDTH-1:0]   sum_red;
  logic [CNT_WIDTH-1:0]    cnt_next;
`ifdef M31_ACC_LEN_LIMIT_EN
  logic                    ovr_hit;
`endif

  // Fold an unreduced sum (at most 2p) back into 0..p-1. The end-around
  // carry cannot overflow DATA_WIDTH bits for inputs bounded by 2p.
  function automatic logic [DATA_WIDTH-1:0] red(input logic [DATA_WIDTH:0] s);
    logic [DATA_WIDTH-1:0] t;
    t = s[DATA_WIDTH-1:0] + DATA_WIDTH'(s[DATA_WIDTH]);
    return (t == '1) ? '0 : t;
  endfunction

  // Accept a new element whenever the output register is empty or draining.
  assign in_ready = ~rst & (~out_valid | out_ready);

  // Next-value datapath: reduced running sum and saturating count.
  always_comb begin
    in_xfer   = in_valid & in_ready;
    out_xfer  = out_valid & out_ready;
    base      = (state == ACCUM) ? acc : '0;
    cnt_base  = (state == ACCUM) ? cnt : '0;
    sum_red   = red({1'b0, base} + {1'b0, in_data});
    cnt_next  = (cnt_base == MAX_CNT) ? MAX_CNT : cnt_base + ONE_CNT;
`ifdef M31_ACC_LEN_LIMIT_EN
    ovr_hit   = ~in_last & (cnt_base == MAX_CNT - ONE_CNT);
    close_pkt = in_last | ovr_hit;
`else
    close_pkt = in_last;
`endif
  end

  // Packet FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_count   <= '0;
`ifdef M31_ACC_LEN_LIMIT_EN
      out_overrun <= 1'b0;
`endif
    end else if (in_xfer && close_pkt) begin
      // A closing transfer reloads the output even while the previous
      // result drains, which sustains one packet per cycle.
      out_data    <= sum_red;
      out_count   <= cnt_next;
      out_valid   <= 1'b1;
`ifdef M31_ACC_LEN_LIMIT_EN
      out_overrun <= ovr_hit;
`endif
      acc         <= '0;
      cnt         <= '0;
      state       <= IDLE;
    end else begin
      if (out_xfer) begin
        out_valid <= 1'b0;
      end
      if (in_xfer) begin
        acc   <= sum_red;
        cnt   <= cnt_next;
        state <= ACCUM;
      end
    end
  end

endmodule

// File: tb/tb_m31_stream_accumulator.sv
// Self-checking bench for m31_stream_accumulator (MAX_LEN overridden to 4).
// Expected sums come from a modulo-arithmetic model and are queued when the
// closing element is accepted; the monitor pops them on each output transfer.
module tb_m31_stream_accumulator;

  localparam int DW  = 31;
  localparam int ML  = 4;
  localparam int CW  = $clog2(ML + 1);
  localparam longint unsigned P = 64'h7FFF_FFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_count;
`ifdef M31_ACC_LEN_LIMIT_EN
  logic          out_overrun;
`endif

  typedef struct {
    longint unsigned data;
    int unsigned     count;
    bit              ovr;
  } exp_t;

  exp_t            sb[$];
  int unsigned     checks = 0;
  int unsigned     errors = 0;
  longint unsigned m_sum  = 0;
  int unsigned     m_cnt  = 0;

  m31_stream_accumulator #(
    .DATA_WIDTH(DW),
    .MAX_LEN   (ML)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count)
`ifdef M31_ACC_LEN_LIMIT_EN
    ,
    .out_overrun(out_overrun)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: every output transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 64'(out_data), 64'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", 64'(out_data), e.data);
        chk("out_count", 64'(out_count), 64'(e.count));
`ifdef M31_ACC_LEN_LIMIT_EN
        chk("out_overrun", 64'(out_overrun), 64'(e.ovr));
`endif
      end
    end
  end

  function automatic void model_push(input bit ovr);
    exp_t e;
    e.data  = m_sum;
    e.count = (m_cnt > ML) ? ML : m_cnt;
    e.ovr   = ovr;
    sb.push_back(e);
    m_sum = 0;
    m_cnt = 0;
  endfunction

  // Drive one element, wait (bounded) for acceptance, update the model.
  task automatic send(input logic [DW-1:0] d, input bit last);
    int unsigned n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 64'(in_ready), 64'd1);
    end else begin
      m_sum = (m_sum + (64'(d) % P)) % P;
      m_cnt++;
      if (last) begin
        model_push(1'b0);
      end
`ifdef M31_ACC_LEN_LIMIT_EN
      else if (m_cnt == ML) begin
        model_push(1'b1);
      end
`endif
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 'x;
    in_last  = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 'x;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Basic packet 1,2,3: single-cycle out_valid pulse one cycle later
    send(31'd1, 1'b0);
    send(31'd2, 1'b0);
    send(31'd3, 1'b1);
    chk("p123_valid", 64'(out_valid), 64'd1);
    chk("p123_data", 64'(out_data), 64'd6);
    @(posedge clk);
    #1;
    chk("p123_valid_drop", 64'(out_valid), 64'd0);

    // Reduction corner cases
    send(31'h7FFF_FFFE, 1'b0);
    send(31'h7FFF_FFFE, 1'b1);
    send(31'h7FFF_FFFE, 1'b0);
    send(31'd1, 1'b1);
    send(31'h7FFF_FFFF, 1'b0);
    send(31'd5, 1'b1);
    send(31'h7FFF_FFFF, 1'b1);

`ifndef M31_ACC_LEN_LIMIT_EN
    // Count saturates at MAX_LEN while the sum keeps accumulating
    for (int i = 0; i < 5; i++) send(31'd1, 1'b0);
    send(31'd1, 1'b1);
`else
    // Fourth unterminated element force-closes the packet
    for (int i = 0; i < 5; i++) send(31'd1, 1'b0);
    send(31'd2, 1'b1);
`endif
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: output held, input stalled
    out_ready = 1'b0;
    send(31'd10, 1'b1);
    in_valid = 1'b1;
    in_data  = 31'd7;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_data", 64'(out_data), 64'd10);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(31'd7, 1'b1);
    chk("bp_next_valid", 64'(out_valid), 64'd1);
    chk("bp_next_data", 64'(out_data), 64'd7);
    chk("bp_next_count", 64'(out_count), 64'd1);
    @(posedge clk);
    #1;

    // Back-to-back single-element packets at one per cycle
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      in_last  = 1'b1;
      @(negedge clk);
      chk("b2b_in_ready", 64'(in_ready), 64'd1);
      m_sum = longint'(i);
      m_cnt = 1;
      model_push(1'b0);
      @(posedge clk);
      #1;
      chk("b2b_valid", 64'(out_valid), 64'd1);
      chk("b2b_data", 64'(out_data), 64'(i));
    end
    in_valid = 1'b0;
    in_data  = 'x;
    in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-packet discards the partial sum
    send(31'd5, 1'b0);
    send(31'd6, 1'b0);
    m_sum = 0;
    m_cnt = 0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_valid_after", 64'(out_valid), 64'd0);
    send(31'd9, 1'b1);
    chk("mid_rst_data", 64'(out_data), 64'd9);
    chk("mid_rst_count", 64'(out_count), 64'd1);

    // Drain the scoreboard (bounded)
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    chk("drain", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
